// File: rtl/disp_pkg.sv
// Shared constants and helpers for the multiplexed hex display scanner.
package disp_pkg;

   localparam int MAX_DIGITS = 8;

   localparam logic [MAX_DIGITS-1:0] ANODE_OFF = '1;
   localparam logic                  DP_OFF    = 1'b1;

   // Wide enough to index any legal digit count.
   typedef logic [$clog2(MAX_DIGITS)-1:0] digit_idx_t;

   function automatic int idx_width(input int digits);
      return (digits > 1) ? $clog2(digits) : 1;
   endfunction

   // Digit i (i>=1) is blanked when it and every digit above it is zero.
   function automatic logic [MAX_DIGITS-1:0] lz_blank_mask(
      input logic [4*MAX_DIGITS-1:0] disp,
      input int                      digits
   );
      logic [MAX_DIGITS-1:0] mask;
      logic                  all_zero;
      mask     = '0;
      all_zero = 1'b1;
      for (int i = MAX_DIGITS - 1; i >= 1; i--) begin
         if (i < digits) begin
            all_zero = all_zero && (disp[4*i +: 4] == 4'h0);
            mask[i]  = all_zero;
         end
      end
      return mask;
   endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running modulo-DIV counter; tick marks the last cycle of each period.
module tick_prescaler #(
   parameter int DIV = 50000
) (
   input  logic                   clk,
   input  logic                   reset,
   output logic                   tick,
   output logic [$clog2(DIV)-1:0] cnt
);

   localparam int CW = $clog2(DIV);

   logic [CW-1:0] cnt_d, cnt_q;

   always_comb begin
      tick  = (cnt_q == CW'(DIV - 1));
      cnt_d = tick ? '0 : cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/hex_display_scanner.sv
// Scans a DIGITS-wide hex value across one shared 7-segment digit bus with
// tear-free frame latching, leading-zero blanking, decimal points and dead time.
module hex_display_scanner
   import disp_pkg::*;
#(
   parameter int DIGITS = 4,
   parameter int DIV    = 50000,
   parameter int DEAD   = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [4*DIGITS-1:0]   value,
   input  logic                  load,
   input  logic                  blank_lz,
   input  logic [DIGITS-1:0]     dp_mask,
   output logic [3:0]            nibble,
   output logic [DIGITS-1:0]     digit_en_n,
   output logic                  dp_n,
   output logic                  frame_done
);

   localparam int IDX_W = idx_width(DIGITS);
   localparam int CW    = $clog2(DIV);

   logic          tick;
   logic [CW-1:0] cnt;

   tick_prescaler #(.DIV(DIV)) u_prescaler (
      .clk   (clk),
      .reset (reset),
      .tick  (tick),
      .cnt   (cnt)
   );

   logic [IDX_W-1:0]      idx_d, idx_q;
   logic [4*DIGITS-1:0]   shadow_d, shadow_q;
   logic [4*DIGITS-1:0]   disp_d, disp_q;
   logic [3:0]            nibble_d, nibble_q;
   logic [DIGITS-1:0]     digit_en_n_d, digit_en_n_q;
   logic                  dp_n_d, dp_n_q;
   logic                  frame_done_d, frame_done_q;

   logic                  frame_bnd;
   logic                  anode_on;
   logic [4*MAX_DIGITS-1:0] disp_pad;
   logic [MAX_DIGITS-1:0] blank_full;

   always_comb begin
      frame_bnd = tick && (idx_q == IDX_W'(DIGITS - 1));

      idx_d = idx_q;
      if (tick) idx_d = frame_bnd ? '0 : idx_q + 1'b1;

      shadow_d = load ? value : shadow_q;
      // A load on the boundary cycle bypasses the shadow so there is no frame of lag.
      disp_d   = frame_bnd ? (load ? value : shadow_q) : disp_q;

      disp_pad                 = '0;
      disp_pad[4*DIGITS-1:0]   = disp_q;
      blank_full               = blank_lz ? lz_blank_mask(disp_pad, DIGITS) : '0;

      anode_on = (int'(cnt) >= DEAD) && !blank_full[digit_idx_t'(idx_q)];

      nibble_d            = disp_q[{idx_q, 2'b00} +: 4];
      digit_en_n_d        = ANODE_OFF[DIGITS-1:0];
      if (anode_on) digit_en_n_d[idx_q] = 1'b0;
      dp_n_d              = (anode_on && dp_mask[idx_q]) ? 1'b0 : DP_OFF;
      frame_done_d        = frame_bnd;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         idx_q        <= '0;
         shadow_q     <= '0;
         disp_q       <= '0;
         nibble_q     <= '0;
         digit_en_n_q <= ANODE_OFF[DIGITS-1:0];
         dp_n_q       <= DP_OFF;
         frame_done_q <= 1'b0;
      end else begin
         idx_q        <= idx_d;
         shadow_q     <= shadow_d;
         disp_q       <= disp_d;
         nibble_q     <= nibble_d;
         digit_en_n_q <= digit_en_n_d;
         dp_n_q       <= dp_n_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign nibble     = nibble_q;
   assign digit_en_n = digit_en_n_q;
   assign dp_n       = dp_n_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Scoreboard bench: a time-based reference model queues expected outputs,
// an independent monitor pops and compares them every cycle.
module tb_hex_display_scanner;

   localparam int DIGITS = 4;
   localparam int DIV    = 4;
   localparam int DEAD   = 1;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] value = '0;
   logic        load = 1'b0;
   logic        blank_lz = 1'b0;
   logic [3:0]  dp_mask = '0;
   logic [3:0]  nibble;
   logic [3:0]  digit_en_n;
   logic        dp_n;
   logic        frame_done;

   int tests = 0;
   int fails = 0;

   logic [9:0] exp_q[$];

   // Reference state: cycles since reset, shadow and displayed value.
   int          m_t = 0;
   logic [15:0] m_shadow = '0;
   logic [15:0] m_disp = '0;

   always #5 clk = ~clk;

   hex_display_scanner #(.DIGITS(DIGITS), .DIV(DIV), .DEAD(DEAD)) dut (
      .clk        (clk),
      .reset      (reset),
      .value      (value),
      .load       (load),
      .blank_lz   (blank_lz),
      .dp_mask    (dp_mask),
      .nibble     (nibble),
      .digit_en_n (digit_en_n),
      .dp_n       (dp_n),
      .frame_done (frame_done)
   );

   function automatic void model_step();
      logic [9:0] e;
      int         pos, dig;
      logic       blank, on, fd;
      logic [3:0] nib, en;
      if (reset) begin
         e        = {4'h0, 4'hF, 1'b1, 1'b0};
         m_t      = 0;
         m_shadow = '0;
         m_disp   = '0;
      end else begin
         pos   = m_t % DIV;
         dig   = (m_t / DIV) % DIGITS;
         nib   = 4'((m_disp >> (4 * dig)) & 16'hF);
         blank = blank_lz && (dig >= 1) && ((m_disp >> (4 * dig)) == 16'h0);
         on    = (pos >= DEAD) && !blank;
         en    = on ? ~(4'b0001 << dig) : 4'hF;
         fd    = (pos == DIV - 1) && (dig == DIGITS - 1);
         e     = {nib, en, !(on && dp_mask[dig]), fd};
         if (fd) m_disp = load ? value : m_shadow;
         if (load) m_shadow = value;
         m_t++;
      end
      exp_q.push_back(e);
   endfunction

   task automatic drive(input logic r, input logic l, input logic [15:0] v,
                        input logic b, input logic [3:0] d);
      @(negedge clk);
      reset    = r;
      load     = l;
      value    = v;
      blank_lz = b;
      dp_mask  = d;
      model_step();
   endtask

   task automatic idle(input int n, input logic b, input logic [3:0] d);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 16'h0, b, d);
   endtask

   // Monitor
   initial begin
      logic [9:0] got, e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = {nibble, digit_en_n, dp_n, frame_done};
            tests++;
            if (got !== e)  begin
               fails++;
               $display("FAIL outputs @%0t: got nibble=%h en_n=%b dp_n=%b fd=%b, required nibble=%h en_n=%b dp_n=%b fd=%b",
                        $time, got[9:6], got[5:2], got[1], got[0], e[9:6], e[5:2], e[1], e[0]);
            end
            tests++;
            if ($countones(~digit_en_n) > 1) begin
               fails++;
               $display("FAIL single_anode @%0t: got en_n=%b, required at most one low bit", $time, digit_en_n);
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   // Stimulus
   initial begin
      logic [15:0] v;
      int          guard;
      // 1: reset then idle scanning of zero
      for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 16'h0, 1'b0, 4'h0);
      idle(20, 1'b0, 4'h0);
      // 2: mid-frame load
      idle(5, 1'b0, 4'h0);
      drive(1'b0, 1'b1, 16'h1A2F, 1'b0, 4'h0);
      idle(40, 1'b0, 4'h0);
      // 3: leading-zero blanking
      drive(1'b0, 1'b1, 16'h0030, 1'b1, 4'h0);
      idle(40, 1'b1, 4'h0);
      drive(1'b0, 1'b1, 16'h0000, 1'b1, 4'h0);
      idle(36, 1'b1, 4'h0);
      // 4: decimal point, visible then blanked
      drive(1'b0, 1'b1, 16'h1234, 1'b0, 4'b0100);
      idle(36, 1'b0, 4'b0100);
      drive(1'b0, 1'b1, 16'h0005, 1'b1, 4'b0100);
      idle(36, 1'b1, 4'b0100);
      // 5: load coinciding with the frame-boundary tick
      guard = 0;
      while ((m_t % (DIV * DIGITS)) != DIV * DIGITS - 1 && guard < 32) begin
         idle(1, 1'b0, 4'h0);
         guard++;
      end
      drive(1'b0, 1'b1, 16'hBEEF, 1'b0, 4'h0);
      idle(20, 1'b0, 4'h0);
      // 6: reset during digit 2's slot
      guard = 0;
      while (((m_t / DIV) % DIGITS) != 2 && guard < 32) begin
         idle(1, 1'b0, 4'h0);
         guard++;
      end
      idle(1, 1'b0, 4'h0);
      drive(1'b1, 1'b0, 16'h0, 1'b0, 4'h0);
      drive(1'b1, 1'b0, 16'h0, 1'b0, 4'h0);
      idle(20, 1'b0, 4'h0);
      // Randomized traffic
      for (int i = 0; i < 2000; i++) begin
         v = 16'($urandom);
         v = v >> (4 * $urandom_range(0, 4));
         drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 7) == 0), v,
               ($urandom_range(0, 3) != 0) ? blank_lz : 1'($urandom),
               ($urandom_range(0, 15) == 0) ? 4'($urandom) : dp_mask);
      end
      @(negedge clk);
      @(negedge clk);
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
